// File: rtl/x32_div_pkg.sv
// Shared constants and state encoding for the 32-by-16 sequential divider.
package x32_div_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/x16_div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module x16_div_step
    import x32_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   r_in,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   r_out,
    output logic                 q_bit
);

    // The partial remainder stays below the divisor, so its top bit is shifted out unused.
    logic                 unused_r_msb;
    logic [DIVISOR_W:0]   trial;

    assign unused_r_msb = r_in[DIVISOR_W];

    // Full 17-bit trial compare; truncating it would lose quotient bits for large divisors.
    always_comb begin
        trial = {r_in[DIVISOR_W-1:0], dvd_bit};
        r_out = trial;
        q_bit = 1'b0;
        if (trial >= {1'b0, divisor}) begin
            r_out = trial - {1'b0, divisor};
            q_bit = 1'b1;
        end
    end

endmodule

// File: rtl/x32_seq_div.sv
// Iterative 32/16 unsigned restoring divider with valid/ready handshakes.
// The first iteration is done on the capture edge, so a normal operation spends
// K-1 cycles in RUN and the result is presented K cycles after acceptance.
module x32_seq_div
    import x32_div_pkg::*;
#(
    parameter int NAPPROX = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  overflow
);

    if (NAPPROX < 0 || NAPPROX > 8) begin : g_bad_napprox
        $error("x32_seq_div: NAPPROX must be in 0..8");
    end

    // Number of quotient bits actually computed.
    localparam int K = DIVISOR_W - NAPPROX;
    // Count K-1 is consumed on the capture edge; RUN walks K-2 down to 0.
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(K - 2);

    div_state_e             state, state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [DIVISOR_W:0]     r_q;
    logic [DIVISOR_W-1:0]   lo_q;
    logic [DIVISOR_W-1:0]   q_acc;
    logic [DIVISOR_W-1:0]   dvs_q;

    logic [DIVISOR_W:0]     step_r, step_r_nxt;
    logic                   step_bit, step_q;
    logic [DIVISOR_W-1:0]   step_dvs;
    logic [DIVISOR_W-1:0]   q_next;
    logic                   is_zero, is_ovf, capture;

    assign is_zero  = (divisor == '0);
    assign is_ovf   = !is_zero && (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor);
    assign capture  = (state == DIV_IDLE) && in_valid;
    assign q_next   = {q_acc[DIVISOR_W-2:0], step_q};
    assign in_ready = (state == DIV_IDLE);
    assign out_valid = (state == DIV_DONE);

    // Feed the step from the live operands while idle, from the working registers while running.
    always_comb begin
        step_r   = r_q;
        step_bit = lo_q[DIVISOR_W-1];
        step_dvs = dvs_q;
        if (state == DIV_IDLE) begin
            step_r   = {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
            step_bit = dividend[DIVISOR_W-1];
            step_dvs = divisor;
        end
    end

    x16_div_step u_step (
        .r_in    (step_r),
        .dvd_bit (step_bit),
        .divisor (step_dvs),
        .r_out   (step_r_nxt),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (in_valid) state_nxt = (is_zero || is_ovf) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt == '0) state_nxt = DIV_DONE;
            DIV_DONE: if (out_ready) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Iteration counter and result/flag registers; results hold their value outside DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (capture) begin
            cnt      <= CNT_FIRST;
            div_zero <= is_zero;
            overflow <= is_ovf;
            if (is_zero) begin
                quotient  <= '1;
                remainder <= dividend[DIVISOR_W-1:0];
            end else if (is_ovf) begin
                quotient  <= '1;
                remainder <= '0;
            end
        end else if (state == DIV_RUN) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                quotient  <= q_next << NAPPROX;
                remainder <= step_r_nxt[DIVISOR_W-1:0];
            end
        end
    end

    // Working registers: partial remainder, pending dividend bits, quotient accumulator.
    always_ff @(posedge clk) begin
        if (capture) begin
            dvs_q <= divisor;
            r_q   <= step_r_nxt;
            lo_q  <= {dividend[DIVISOR_W-2:0], 1'b0};
            q_acc <= {{(DIVISOR_W-1){1'b0}}, step_q};
        end else if (state == DIV_RUN) begin
            r_q   <= step_r_nxt;
            lo_q  <= {lo_q[DIVISOR_W-2:0], 1'b0};
            q_acc <= q_next;
        end
    end

endmodule

// File: tb/tb_x32_seq_div.sv
// Directed and randomized self-checking bench for x32_seq_div (exact and NAPPROX=4 builds).
module tb_x32_seq_div;

    logic        clk = 1'b0;
    logic        resetn;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, div_zero0, overflow0;
    logic [31:0] dividend0;
    logic [15:0] divisor0, quotient0, remainder0;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, div_zero4, overflow4;
    logic [31:0] dividend4;
    logic [15:0] divisor4, quotient4, remainder4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    x32_seq_div #(.NAPPROX(0)) dut0 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .dividend(dividend0), .divisor(divisor0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .quotient(quotient0), .remainder(remainder0),
        .div_zero(div_zero0), .overflow(overflow0)
    );

    x32_seq_div #(.NAPPROX(4)) dut4 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .dividend(dividend4), .divisor(divisor4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .quotient(quotient4), .remainder(remainder4),
        .div_zero(div_zero4), .overflow(overflow4)
    );

    // Issue one op to dut0 (called 1 ns after a rising edge, DUT idle) and take its result.
    // lat = rising edges from acceptance to the first edge that sees out_valid high.
    task automatic do_op0(input logic [31:0] a, input logic [15:0] b, output int lat,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic [1:0] flags, output int busy_bad);
        dividend0 = a; divisor0 = b; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        lat = 1; busy_bad = 0;
        while (!out_valid0 && lat < 40) begin
            if (in_ready0) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready0) busy_bad++;
        q = quotient0; r = remainder0; flags = {div_zero0, overflow0};
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
    endtask

    task automatic do_op4(input logic [31:0] a, input logic [15:0] b, output int lat,
                          output logic [15:0] q, output logic [15:0] r);
        dividend4 = a; divisor4 = b; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient4; r = remainder4;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({in_ready0, out_valid0, quotient0, remainder0, div_zero0, overflow0} !==
            {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut0: got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b, want 1 0 0000 0000 0 0",
                     in_ready0, out_valid0, quotient0, remainder0, div_zero0, overflow0);
        end
        n_checks++;
        if ({in_ready4, out_valid4, quotient4, remainder4, div_zero4, overflow4} !==
            {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut4: got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b, want 1 0 0000 0000 0 0",
                     in_ready4, out_valid4, quotient4, remainder4, div_zero4, overflow4);
        end
    endtask

    task automatic test_normal(input logic [31:0] a, input logic [15:0] b,
                               input logic [15:0] eq, input logic [15:0] er);
        int lat, busy;
        logic [15:0] q, r;
        logic [1:0]  fl;
        do_op0(a, b, lat, q, r, fl, busy);
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL normal_latency %0d/%0d: got %0d want 16", a, b, lat); end
        n_checks++;
        if (q !== eq) begin n_fail++; $display("FAIL normal_quotient %0d/%0d: got %0d want %0d", a, b, q, eq); end
        n_checks++;
        if (r !== er) begin n_fail++; $display("FAIL normal_remainder %0d/%0d: got %0d want %0d", a, b, r, er); end
        n_checks++;
        if (fl !== 2'b00) begin n_fail++; $display("FAIL normal_flags %0d/%0d: got %b want 00", a, b, fl); end
        n_checks++;
        if (busy !== 0) begin n_fail++; $display("FAIL normal_in_ready_busy: in_ready high in %0d busy cycles, want 0", busy); end
        n_checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL normal_after_take: got rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
        end
    endtask

    task automatic test_special(input logic [31:0] a, input logic [15:0] b,
                                input logic [15:0] er, input logic [1:0] efl);
        int lat, busy;
        logic [15:0] q, r;
        logic [1:0]  fl;
        do_op0(a, b, lat, q, r, fl, busy);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL special_latency %h/%h: got %0d want 1", a, b, lat); end
        n_checks++;
        if (q !== 16'hFFFF) begin n_fail++; $display("FAIL special_quotient %h/%h: got %h want ffff", a, b, q); end
        n_checks++;
        if (r !== er) begin n_fail++; $display("FAIL special_remainder %h/%h: got %h want %h", a, b, r, er); end
        n_checks++;
        if (fl !== efl) begin n_fail++; $display("FAIL special_flags %h/%h: got dz,ov=%b want %b", a, b, fl, efl); end
    endtask

    task automatic test_random_exact();
        int lat, busy;
        logic [15:0] q, r, b;
        logic [31:0] a, eq, er;
        logic [1:0]  fl;
        for (int i = 0; i < 300; i++) begin
            b = 16'($urandom_range(1, 65535));
            a = {16'($urandom % b), 16'($urandom)};
            eq = a / {16'h0, b};
            er = a % {16'h0, b};
            do_op0(a, b, lat, q, r, fl, busy);
            n_checks++;
            if ({q, r, fl} !== {eq[15:0], er[15:0], 2'b00}) begin
                n_fail++;
                $display("FAIL rand_exact %h/%h: got q=%h r=%h fl=%b want q=%h r=%h fl=00",
                         a, b, q, r, fl, eq[15:0], er[15:0]);
            end
        end
    endtask

    task automatic test_approx();
        int lat;
        logic [15:0] q, r, b;
        logic [31:0] a, ex, eq, er;
        do_op4(32'd1000, 16'd7, lat, q, r);
        n_checks++;
        if (lat !== 12) begin n_fail++; $display("FAIL approx_latency: got %0d want 12", lat); end
        n_checks++;
        if (q !== 16'h0080) begin n_fail++; $display("FAIL approx_quotient 1000/7: got %h want 0080", q); end
        n_checks++;
        if (r !== 16'd6) begin n_fail++; $display("FAIL approx_remainder 1000/7: got %0d want 6", r); end
        for (int i = 0; i < 3000; i++) begin
            b = 16'($urandom_range(1, 65535));
            a = {16'($urandom % b), 16'($urandom)};
            ex = a / {16'h0, b};
            eq = (a >> 4) / {16'h0, b};
            er = (a >> 4) % {16'h0, b};
            do_op4(a, b, lat, q, r);
            n_checks++;
            if (q[15:4] !== ex[15:4] || q[3:0] !== 4'h0 || q !== {eq[11:0], 4'h0} || r !== er[15:0]) begin
                n_fail++;
                $display("FAIL rand_approx %h/%h: got q=%h r=%h want q=%h (exact %h) r=%h",
                         a, b, q, r, {eq[11:0], 4'h0}, ex[15:0], er[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        dividend0 = 32'hFFFE_0001; divisor0 = 16'hFFFF; in_valid0 = 1'b1; out_ready0 = 1'b0;
        @(posedge clk); #1;
        // Second op is presented immediately and must wait for the first result to be taken.
        dividend0 = 32'd1000; divisor0 = 16'd7;
        lat = 1;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 16) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 16", lat); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({out_valid0, in_ready0, quotient0, remainder0} !== {1'b1, 1'b0, 16'hFFFF, 16'h0000}) begin
                n_fail++;
                $display("FAIL b2b_stall_cycle%0d: got vld=%b rdy=%b q=%h r=%h want 1 0 ffff 0000",
                         i, out_valid0, in_ready0, quotient0, remainder0);
            end
            @(posedge clk); #1;
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        n_checks++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_after_take: got rdy=%b vld=%b want 1 0", in_ready0, out_valid0);
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        n_checks++;
        if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got rdy=%b want 0", in_ready0); end
        lat = 1;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if ({lat, quotient0, remainder0} !== {32'd16, 16'd142, 16'd6}) begin
            n_fail++;
            $display("FAIL b2b_second_result: got lat=%0d q=%0d r=%0d want 16 142 6", lat, quotient0, remainder0);
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen, lat, busy;
        logic [15:0] q, r;
        logic [1:0]  fl;
        dividend0 = 32'd65535; divisor0 = 16'd3; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        resetn = 1'b0;
        #2;
        n_checks++;
        if ({out_valid0, quotient0, remainder0, div_zero0, overflow0} !== {1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got vld=%b q=%h r=%h dz=%b ov=%b want 0 0000 0000 0 0",
                     out_valid0, quotient0, remainder0, div_zero0, overflow0);
        end
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 1", in_ready0); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid0) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_result: out_valid high %0d cycles, want 0", seen); end
        do_op0(32'd9, 16'd3, lat, q, r, fl, busy);
        n_checks++;
        if ({lat, q, r, fl} !== {32'd16, 16'd3, 16'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL midreset_next_op 9/3: got lat=%0d q=%0d r=%0d fl=%b want 16 3 0 00", lat, q, r, fl);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; dividend0 = '0; divisor0 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; dividend4 = '0; divisor4 = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_normal(32'd1000, 16'd7, 16'd142, 16'd6);
        test_special(32'h0001_0000, 16'd1, 16'h0000, 2'b01);
        test_special(32'h1234_5678, 16'd0, 16'h5678, 2'b10);
        test_normal(32'd100, 16'd10, 16'd10, 16'd0);
        test_normal(32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000);
        test_random_exact();
        test_approx();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
